perf_sampler: RTL and testbench



---
 rtl/perf_sampler.sv | 192 +++++++++++++++++++
 tb/tb_perf_sampler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_sampler.sv
// Periodic/triggered sweep of the counter bank into a FWFT sample FIFO; CSR traffic wins the bank port.
// Request in t -> capture from t+1 -> smp_valid_o at t+2; CSR access or a full FIFO stalls the sweep in place.

module perf_sampler_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_full,
  output logic         o_pop_vld,
  input  logic         i_pop_rdy,
  output logic [W-1:0] o_pop_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_pop_vld = (r_wptr != r_rptr);
  assign o_pop_dat = r_mem[r_rptr[PW-1:0]];
  assign w_push    = i_push_vld && !o_full;
  assign w_pop     = o_pop_vld && i_pop_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing reads it until the pointers say it holds data.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_push_dat;
  end
endmodule

module perf_sampler #(
  parameter int FIRST_ADDR    = 3,
  parameter int NR_COUNTERS   = 14,
  parameter int PERIOD        = 30000,
  parameter int FIFO_DEPTH    = 4,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        debug_mode_i,
  input  logic        enable_i,
  input  logic        trigger_i,
  input  logic        csr_req_i,
  input  logic [4:0]  csr_addr_i,
  input  logic        csr_we_i,
  input  logic [63:0] csr_wdata_i,
  output logic [63:0] csr_rdata_o,
  output logic [4:0]  perf_addr_o,
  output logic        perf_we_o,
  output logic [63:0] perf_wdata_o,
  input  logic [63:0] perf_data_i,
  output logic        smp_valid_o,
  input  logic        smp_ready_i,
  output logic [4:0]  smp_addr_o,
  output logic [63:0] smp_data_o,
  output logic        smp_first_o,
  output logic        smp_last_o,
  output logic        busy_o,
  output logic [15:0] overrun_cnt_o
);
  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        first;
    logic        last;
  } smp_t;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_idx;
  logic [4:0]  w_idx_nxt;
  logic        r_done;
  logic [15:0] r_timer;
  logic [15:0] r_overrun;

  logic        w_tick;
  logic        w_req;
  logic        w_capture;
  logic        w_drop;
  logic        w_last_idx;
  logic [4:0]  w_smp_addr;
  logic        w_fifo_full;
  logic        w_fifo_vld;
  smp_t        w_push_dat;
  smp_t        w_pop_dat;
  smp_t        w_out;

  assign w_tick     = enable_i && (r_timer == 16'(PERIOD - 1));
  assign w_req      = w_tick || trigger_i;
  assign w_last_idx = (r_idx == 5'(NR_COUNTERS - 1));
  assign w_smp_addr = 5'(FIRST_ADDR) + r_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The cycle right after a sweep ends still counts as busy for new requests.
        if (w_req && r_done) begin
          w_drop = 1'b1;
        end else if (w_req && !debug_mode_i) begin
          w_state_nxt = S_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      S_SWEEP: begin
        w_drop = w_req;
        if (!csr_req_i && !w_fifo_full) begin
          w_capture = 1'b1;
          if (w_last_idx) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_timer   <= '0;
      r_overrun <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_capture && w_last_idx;
      if (!enable_i || w_tick) r_timer <= '0;
      else                     r_timer <= r_timer + 1'b1;
      if (w_drop && (r_overrun != 16'hFFFF)) r_overrun <= r_overrun + 1'b1;
    end
  end

  assign perf_addr_o  = csr_req_i ? csr_addr_i  : w_smp_addr;
  assign perf_we_o    = csr_req_i ? csr_we_i    : (w_capture && (CLEAR_ON_READ != 0));
  assign perf_wdata_o = csr_req_i ? csr_wdata_i : 64'd0;
  assign csr_rdata_o  = perf_data_i;

  assign w_push_dat.addr  = w_smp_addr;
  assign w_push_dat.data  = perf_data_i;
  assign w_push_dat.first = (r_idx == 5'd0);
  assign w_push_dat.last  = w_last_idx;

  perf_sampler_fifo #(
    .W     ($bits(smp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_push_vld (w_capture),
    .i_push_dat (w_push_dat),
    .o_full     (w_fifo_full),
    .o_pop_vld  (w_fifo_vld),
    .i_pop_rdy  (smp_ready_i),
    .o_pop_dat  (w_pop_dat)
  );

  // Payload is forced to zero while empty so stale entries never leak out.
  assign w_out         = w_fifo_vld ? w_pop_dat : '0;
  assign smp_valid_o   = w_fifo_vld;
  assign smp_addr_o    = w_out.addr;
  assign smp_data_o    = w_out.data;
  assign smp_first_o   = w_out.first;
  assign smp_last_o    = w_out.last;
  assign busy_o        = (r_state == S_SWEEP);
  assign overrun_cnt_o = r_overrun;
endmodule

// File: tb/tb_perf_sampler.sv
// Scoreboard bench for perf_sampler: stimulus queues expected samples, a monitor pops and compares them.
module tb_perf_sampler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        debug_mode, enable, trigger, csr_req, csr_we, smp_ready;
  logic [4:0]  csr_addr;
  logic [63:0] csr_wdata, csr_rdata, perf_wdata, perf_data;
  logic [4:0]  perf_addr, smp_addr;
  logic        perf_we, smp_valid, smp_first, smp_last, busy;
  logic [63:0] smp_data;
  logic [15:0] overrun;

  logic        trigger2;
  logic [63:0] csr_rdata2, perf_wdata2, perf_data2, smp_data2;
  logic [4:0]  perf_addr2, smp_addr2;
  logic        perf_we2, smp_valid2, smp_first2, smp_last2, busy2;
  logic [15:0] overrun2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seen5 = 0;
  bit rec_first = 0;
  int first_times[$];

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        first;
    logic        last;
  } exp_t;
  exp_t sb_q[$];

  logic [63:0] bank  [32];
  logic [63:0] bank2 [32];

  function automatic logic [63:0] init_val(int a);
    return {32'hC0DE_0000 | 32'(a), 32'h1000 + 32'(a * 3)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        bank[i]  <= init_val(i);
        bank2[i] <= (i == 5) ? 64'd100 : init_val(i);
      end
    end else begin
      if (perf_we)  bank[perf_addr]   <= perf_wdata;
      if (perf_we2) bank2[perf_addr2] <= perf_wdata2;
    end
  end
  assign perf_data  = bank[perf_addr];
  assign perf_data2 = bank2[perf_addr2];

  perf_sampler #(.FIRST_ADDR(3), .NR_COUNTERS(14), .PERIOD(16), .FIFO_DEPTH(4), .CLEAR_ON_READ(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug_mode), .enable_i(enable), .trigger_i(trigger),
    .csr_req_i(csr_req), .csr_addr_i(csr_addr), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .perf_addr_o(perf_addr), .perf_we_o(perf_we), .perf_wdata_o(perf_wdata),
    .perf_data_i(perf_data), .smp_valid_o(smp_valid), .smp_ready_i(smp_ready), .smp_addr_o(smp_addr),
    .smp_data_o(smp_data), .smp_first_o(smp_first), .smp_last_o(smp_last), .busy_o(busy),
    .overrun_cnt_o(overrun));

  perf_sampler #(.FIRST_ADDR(3), .NR_COUNTERS(4), .PERIOD(16), .FIFO_DEPTH(4), .CLEAR_ON_READ(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(1'b0), .enable_i(1'b0), .trigger_i(trigger2),
    .csr_req_i(1'b0), .csr_addr_i(5'd0), .csr_we_i(1'b0), .csr_wdata_i(64'd0),
    .csr_rdata_o(csr_rdata2), .perf_addr_o(perf_addr2), .perf_we_o(perf_we2), .perf_wdata_o(perf_wdata2),
    .perf_data_i(perf_data2), .smp_valid_o(smp_valid2), .smp_ready_i(1'b1), .smp_addr_o(smp_addr2),
    .smp_data_o(smp_data2), .smp_first_o(smp_first2), .smp_last_o(smp_last2), .busy_o(busy2),
    .overrun_cnt_o(overrun2));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted sample is compared against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && smp_valid && smp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: got addr %0d, expected no sample", smp_addr);
      end else begin
        e = sb_q.pop_front();
        chk("smp_addr", 64'(smp_addr), 64'(e.addr));
        chk("smp_data", smp_data, e.data);
        chk("smp_first", 64'(smp_first), 64'(e.first));
        chk("smp_last", 64'(smp_last), 64'(e.last));
      end
      if (smp_first && rec_first) first_times.push_back(cyc);
    end
    if (rst_n && smp_valid2 && smp_addr2 == 5'd5) begin
      chk("cor_sample5", smp_data2, 64'd100);
      seen5++;
    end
  end

  task automatic push_sweep();
    exp_t e;
    for (int a = 0; a < 14; a++) begin
      e.addr  = 5'(3 + a);
      e.data  = init_val(3 + a);
      e.first = (a == 0);
      e.last  = (a == 13);
      sb_q.push_back(e);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  task automatic wait_drain(string name, int limit);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < limit) begin
      step(1);
      n++;
    end
    step(2);
    checks++;
    if (sb_q.size() != 0 || busy) begin
      failures++;
      $display("FAIL %s_timeout: got %0d samples outstanding, expected 0", name, sb_q.size());
    end
  endtask

  initial begin
    int busy_cnt;
    int bad;
    debug_mode = 0; enable = 0; trigger = 0; trigger2 = 0; csr_req = 0; csr_we = 0;
    csr_addr = '0; csr_wdata = '0; smp_ready = 1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(smp_valid), 0);
    chk("rst_overrun", 64'(overrun), 0);
    chk("rst_smp_addr", 64'(smp_addr), 0);
    chk("rst_smp_data", smp_data, 0);
    chk("rst_perf_we", 64'(perf_we), 0);
    rst_n = 1'b1;
    step(1);

    // Periodic sweeps: three ticks within 48 enabled cycles.
    rec_first = 1;
    push_sweep(); push_sweep(); push_sweep();
    trigger2 = 1'b1;
    enable = 1'b1;
    step(1);
    trigger2 = 1'b0;
    step(47);
    enable = 1'b0;
    wait_drain("periodic", 200);
    rec_first = 0;
    chk("period_sweeps", 64'(first_times.size()), 3);
    if (first_times.size() == 3) begin
      chk("period_gap1", 64'(first_times[1] - first_times[0]), 16);
      chk("period_gap2", 64'(first_times[2] - first_times[1]), 16);
    end
    chk("period_overrun", 64'(overrun), 0);

    // Backpressure: four captures fill the FIFO, then the sweep stalls.
    smp_ready = 1'b0;
    push_sweep();
    pulse_trigger();
    step(20);
    @(negedge clk);
    chk("stall_busy", 64'(busy), 1);
    chk("stall_perf_addr", 64'(perf_addr), 7);
    chk("stall_perf_we", 64'(perf_we), 0);
    chk("stall_valid", 64'(smp_valid), 1);
    chk("stall_smp_addr", 64'(smp_addr), 3);
    step(1);
    smp_ready = 1'b1;
    wait_drain("stall", 200);

    // CSR traffic on every other cycle halves the sweep rate.
    push_sweep();
    pulse_trigger();
    busy_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      csr_req   = k[0];
      csr_we    = (k % 4 == 3);
      csr_addr  = (k % 4 == 3) ? 5'd25 : 5'd20;
      csr_wdata = 64'hBEEF_0000 + 64'(k);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (k % 4 == 1) chk("csr_rdata", csr_rdata, init_val(20));
      if (k % 4 == 3) begin
        chk("csr_perf_addr", 64'(perf_addr), 25);
        chk("csr_perf_we", 64'(perf_we), 1);
        chk("csr_perf_wdata", perf_wdata, 64'hBEEF_0000 + 64'(k));
      end
      step(1);
    end
    csr_req = 1'b0; csr_we = 1'b0;
    chk("csr_sweep_cycles", 64'(busy_cnt), 28);
    chk("csr_bank_write", bank[25], 64'hBEEF_0000 + 64'd27);
    wait_drain("csr", 200);

    // A second request during a sweep is dropped and counted.
    push_sweep();
    pulse_trigger();
    step(3);
    pulse_trigger();
    wait_drain("overrun", 200);
    step(5);
    chk("overrun_one", 64'(overrun), 1);

    // Debug mode suppresses the periodic tick without counting it.
    debug_mode = 1'b1;
    enable = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bad++;
      step(1);
    end
    enable = 1'b0;
    debug_mode = 1'b0;
    step(2);
    chk("debug_no_sweep", 64'(bad), 0);
    chk("debug_no_overrun", 64'(overrun), 1);

    chk("cor_seen5", 64'(seen5), 1);
    chk("cor_bank5", bank2[5], 0);
    chk("cor_bank3", bank2[3], 0);
    chk("cor_bank7", bank2[7], init_val(7));

    // Overrun saturation while the sweep is stalled on a full FIFO.
    smp_ready = 1'b0;
    trigger = 1'b1;
    step(65540);
    trigger = 1'b0;
    @(negedge clk);
    chk("sat_overrun", 64'(overrun), 16'hFFFF);
    chk("sat_busy", 64'(busy), 1);

    // Reset mid-sweep discards the partial sweep and flushes the FIFO.
    step(1);
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", 64'(smp_valid), 0);
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_overrun", 64'(overrun), 0);
    chk("mrst_smp_addr", 64'(smp_addr), 0);
    chk("mrst_smp_data", smp_data, 0);
    chk("mrst_first_last", {smp_first, smp_last}, 0);
    step(2);
    rst_n = 1'b1;
    smp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(smp_valid), 0);
    step(1);
    push_sweep();
    pulse_trigger();
    wait_drain("post_reset", 200);

    step(10);
    chk("scoreboard_empty", 64'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
